// File: rtl/wb_mem_pkg.sv
// Shared types and constants for the pipelined Wishbone memory slave.
package wb_mem_pkg;

   localparam int LFSR_W = 16;
   // Galois taps 16,14,13,11
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 8;

   // One response pipeline stage
   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } resp_t;

   localparam resp_t RESP_IDLE = '{valid: 1'b0, data: 32'h0};

   // One right-shift step of the Galois LFSR
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      lfsr_next = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/wb_mem_lfsr.sv
// Free-running 16-bit Galois LFSR with asynchronous reset to SEED.
// Reusable by any bench slave that needs a cheap pseudo-random source.
module wb_mem_lfsr
   import wb_mem_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   // Next state is one Galois step from the current state
   always_comb begin
      state_d = lfsr_next(state_q);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= SEED;
      else         state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone slave memory: one request per cycle, in-order acks
// after LATENCY cycles, byte-enabled writes, optional stall injection.
module wb_mem_slave
   import wb_mem_pkg::*;
#(
   parameter int              AW         = 12,
   parameter int              LATENCY    = 2,
   parameter int              STALL_EN   = 0,
   parameter int              STALL_RATE = 4,
   parameter logic [15:0]     STALL_SEED = 16'hACE1,
   parameter string           INIT_FILE  = ""
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        cyc,
   input  logic        stb,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        ack,
   output logic        stall
);

   localparam int DEPTH = 1 << AW;

   // Elaboration-time guards on parameter ranges
   if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("wb_mem_slave: LATENCY must be in 1..8");
   end
   if (STALL_RATE < 0 || STALL_RATE > 16) begin : g_bad_rate
      $error("wb_mem_slave: STALL_RATE must be in 0..16");
   end
   if (STALL_SEED == 16'h0) begin : g_bad_seed
      $error("wb_mem_slave: STALL_SEED must be nonzero");
   end

   logic [31:0]       mem [DEPTH];
   logic [AW-1:0]     word_idx;
   logic [LFSR_W-1:0] lfsr_state;
   logic              stall_raw;
   logic              accept;
   resp_t             pipe_q [LATENCY];
   resp_t             pipe_d [LATENCY];

   // Upper address bits alias; byte offset is irrelevant for word access
   assign word_idx = addr[AW+1:2];

   wb_mem_lfsr #(.SEED(STALL_SEED)) u_lfsr (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .state   (lfsr_state)
   );

   // Stall decision from the registered LFSR state, stable all cycle
   always_comb begin
      stall_raw = 1'b0;
      if (STALL_EN != 0) stall_raw = ({1'b0, lfsr_state[3:0]} < 5'(STALL_RATE));
   end

   assign stall  = stall_raw & ~sys_rst;
   assign accept = cyc & stb & ~stall & ~sys_rst;

   // NOTE: the memory array has no reset; contents stay undefined until written.
   always_ff @(posedge sys_clk) begin
      if (accept && we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[word_idx][8*i +: 8] <= data_in[8*i +: 8];
         end
      end
   end

   // Next pipeline contents: load stage 0, shift the rest, wipe all on abort
   always_comb begin
      // NOTE: every stage gets a default first so no path leaves pipe_d unassigned (no latch).
      for (int i = 0; i < LATENCY; i++) pipe_d[i] = RESP_IDLE;
      if (cyc) begin
         pipe_d[0].valid = accept;
         pipe_d[0].data  = (accept && !we) ? mem[word_idx] : 32'h0;
         for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
      end
   end

   // Response shift register; reset drops pending acks asynchronously
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= RESP_IDLE;
      end else begin
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
      end
   end

   assign ack      = pipe_q[LATENCY-1].valid;
   assign data_out = pipe_q[LATENCY-1].data;

   logic unused_bits;
   assign unused_bits = ^{addr[31:AW+2], addr[1:0], lfsr_state};

endmodule
